// File: rtl/alu_arbiter.sv
// ============================================================================
// Module      : alu_arbiter
// Description : Two-requester arbiter in front of a shared combinational ALU,
//               with registered operands and a ready/valid result port.
//               Define ALU_ARB_RR_EN for round-robin, otherwise fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_arbiter #(
    parameter int WIDTH = 64,
    parameter int SELW  = 4
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_x,
    input  logic [WIDTH-1:0] req0_y,
    input  logic [SELW-1:0]  req0_sel,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_x,
    input  logic [WIDTH-1:0] req1_y,
    input  logic [SELW-1:0]  req1_sel,

    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic [SELW-1:0]  alu_sel,
    input  logic [WIDTH-1:0] alu_z,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_z,
    output logic             rsp_id
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  op_x_q, op_x_d;
    logic [WIDTH-1:0]  op_y_q, op_y_d;
    logic [SELW-1:0]   op_sel_q, op_sel_d;
    logic [WIDTH-1:0]  rsp_z_q, rsp_z_d;
    logic              rsp_id_q, rsp_id_d;

    logic              grant_any;
    logic              pick1;

    // Ready is only offered from IDLE and never while reset is held.
    assign grant_any = (state_q == S_IDLE) && !rst && (req0_valid || req1_valid);

`ifdef ALU_ARB_RR_EN
    logic ptr_q, ptr_d;

    assign pick1 = req1_valid && (!req0_valid || ptr_q);

    always_comb begin
        ptr_d = ptr_q;
        if (grant_any) begin
            ptr_d = !pick1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign pick1 = req1_valid && !req0_valid;
`endif

    assign req0_ready = grant_any && !pick1;
    assign req1_ready = grant_any && pick1;

    always_comb begin
        state_d  = state_q;
        op_x_d   = op_x_q;
        op_y_d   = op_y_q;
        op_sel_d = op_sel_q;
        rsp_z_d  = rsp_z_q;
        rsp_id_d = rsp_id_q;
        case (state_q)
            S_IDLE: begin
                if (grant_any) begin
                    op_x_d   = pick1 ? req1_x   : req0_x;
                    op_y_d   = pick1 ? req1_y   : req0_y;
                    op_sel_d = pick1 ? req1_sel : req0_sel;
                    rsp_id_d = pick1;
                    state_d  = S_EXEC;
                end
            end
            S_EXEC: begin
                rsp_z_d = alu_z;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_x_q   <= '0;
            op_y_q   <= '0;
            op_sel_q <= '0;
            rsp_z_q  <= '0;
            rsp_id_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_x_q   <= op_x_d;
            op_y_q   <= op_y_d;
            op_sel_q <= op_sel_d;
            rsp_z_q  <= rsp_z_d;
            rsp_id_q <= rsp_id_d;
        end
    end

    // The ALU only ever sees latched operands, so requester churn cannot
    // disturb an operation already in flight.
    assign alu_x     = op_x_q;
    assign alu_y     = op_y_q;
    assign alu_sel   = op_sel_q;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_z     = rsp_z_q;
    assign rsp_id    = rsp_id_q;

endmodule

`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 64, operand and result width in bits.
REQ-002 Parameter SELW, default 4, ALU function-select width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req0_valid  input  1  requester 0 has an operation pending.
REQ-006 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-007 req0_x, req0_y  input  WIDTH each  requester 0 operands.
REQ-008 req0_sel  input  SELW  requester 0 ALU function select.
REQ-009 req1_valid, req1_ready, req1_x, req1_y, req1_sel  as REQ-005..008 for requester 1.
REQ-010 alu_x, alu_y  output  WIDTH each  operands driven to the shared alu.
REQ-011 alu_sel  output  SELW  function select driven to the shared alu (alusel).
REQ-012 alu_z  input  WIDTH  combinational result from the shared alu.
REQ-013 rsp_valid  output  1  result available.
REQ-014 rsp_ready  input  1  consumer accepts result.
REQ-015 rsp_z  output  WIDTH  registered result.
REQ-016 rsp_id  output  1  requester that owns rsp_z (0 or 1).

Function
REQ-017 FSM states IDLE, EXEC, RESP; exactly one active.
REQ-018 IDLE: no request valid -> stay IDLE, both readys 0.
REQ-019 IDLE: one request valid -> that reqN_ready=1 combinationally same cycle; next edge latch its x/y/sel into operand regs, grant id into rsp_id, go EXEC.
REQ-020 IDLE, both valid: winner per REQ-030/031; loser ready stays 0 and must hold its request.
REQ-021 readys SHALL be 0 in EXEC and RESP regardless of valid.
REQ-022 alu_x/alu_y/alu_sel SHALL be driven from operand regs only; they change only on grant edge.
REQ-023 EXEC: next edge capture alu_z into rsp_z, set rsp_valid=1, go RESP (grant-to-rsp_valid latency 2 edges).
REQ-024 RESP: rsp_valid=1, rsp_z and rsp_id stable until rsp_ready=1; on that edge rsp_valid=0, go IDLE.
REQ-025 rsp_ready while rsp_valid=0 SHALL be ignored.
REQ-026 New grant only from IDLE; peak throughput one op per 3 cycles.
REQ-027 Requester changing operands while valid and not ready SHALL not affect any in-flight result.
REQ-028 Arithmetic entirely in alu; no width change, rsp_z = alu_z bit-exact.

Reset
REQ-029 rst=1 at edge: state IDLE, rsp_valid=0, rsp_z=0, rsp_id=0, operand regs 0, alu_sel=0, priority pointer=0; readys 0 while rst=1; reset mid-EXEC/RESP discards the operation, no response.

Configuration
REQ-030 Macro ALU_ARB_RR_EN defined: round-robin; pointer names preferred requester, after each grant pointer = other requester; on tie preferred wins.
REQ-031 ALU_ARB_RR_EN undefined: fixed priority, requester 0 always wins ties; pointer logic absent.

Verification
REQ-032 Reset then req0 x=-240 (0x...FF10), y=15, sel=add-code -> req0_ready cycle 0, rsp_valid at cycle 2, rsp_z=0x...FF1F, rsp_id=0.
REQ-033 Both valid continuously, rsp_ready=1: with ALU_ARB_RR_EN ids alternate 0,1,0,1; without, ids 0,0,0,0 and req1_ready never 1.
REQ-034 rsp_ready held 0 for 5 cycles in RESP -> rsp_z/rsp_id constant, rsp_valid=1, readys 0; release -> IDLE next edge.
REQ-035 Sweep sel 0..9 with x=-240, y=15 via req1 -> each rsp_z equals direct alu output for same inputs.
REQ-036 rst asserted during EXEC -> next cycle rsp_valid=0, state IDLE, no stale response after rst drops.
